// File: rtl/dice_pkg.sv
// Shared types and constants for the dice launcher roll path.
package dice_pkg;

   localparam int          FACE_W    = 7;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;   // x^16+x^14+x^13+x^11+1

   typedef enum logic [1:0] {IDLE, ROLL, REDUCE, SHOW} state_t;

   // One right-shift step of the Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Roll request / result bundle between the launcher front end and the roller.
interface dice_roller_if;
   import dice_pkg::*;

   logic [FACE_W-1:0] NB_Face;
   logic              Roll;
   logic [FACE_W-1:0] Result;
   logic              Rolling;
   logic              Valid;
   logic              Error;

   modport master (output NB_Face, Roll, input Result, Rolling, Valid, Error);
   modport slave  (input NB_Face, Roll, output Result, Rolling, Valid, Error);
endinterface

// File: rtl/dice_roller_lfsr16.sv
// Free-running 16-bit Galois LFSR; a non-zero seed keeps it off the all-zero lock-up state.
module lfsr16
   import dice_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic [15:0] state
);

   // Advance once per clock, reload the seed on reset.
   always_ff @(posedge Clk) begin
      if (Reset) state <= SEED;
      else       state <= lfsr_next(state);
   end

endmodule

// File: rtl/dice_roller.sv
// Dice roller: on a roll press animates for a fixed time, then draws 1..N
// by reducing a 7-bit LFSR sample modulo N one subtraction per cycle.
module dice_roller
   import dice_pkg::*;
#(
   parameter int          ROLL_CYCLES = 25000000,
   parameter int          ANIM_DIV    = 2500000,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic          Clk,
   input logic          Reset,
   dice_roller_if.slave bus
);

   localparam int PH_W = $clog2(ROLL_CYCLES + 1);
   localparam int AN_W = $clog2(ANIM_DIV + 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(ROLL_CYCLES - 1);
   localparam logic [AN_W-1:0] AN_LAST = AN_W'(ANIM_DIV - 1);

   typedef logic [FACE_W-1:0] face_t;

   state_t          state_q, state_d;
   face_t           n_q, n_d, r_q, r_d, result_q, result_d;
   logic            valid_q, valid_d, error_q, error_d, rolling_q, rolling_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [AN_W-1:0] anim_q, anim_d;
   logic            sync1, sync2, roll_prev, req;
   logic [15:0]     lfsr_state;
   logic            unused_lfsr_hi;

   assign unused_lfsr_hi = ^lfsr_state[15:FACE_W];

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .state (lfsr_state)
   );

   // Bring the raw button into the clock domain and turn its rising edge into a one-cycle req.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         roll_prev <= 1'b0;
      end else begin
         sync1     <= bus.Roll;
         sync2     <= sync1;
         roll_prev <= sync2;
      end
   end

   assign req = sync2 & ~roll_prev;

   // State and datapath registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         n_q       <= '0;
         r_q       <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         rolling_q <= 1'b0;
         phase_q   <= '0;
         anim_q    <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         r_q       <= r_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         rolling_q <= rolling_d;
         phase_q   <= phase_d;
         anim_q    <= anim_d;
      end
   end

   // Next-state and datapath update for the roll sequence.
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      r_d      = r_q;
      result_d = result_q;
      valid_d  = valid_q;
      error_d  = error_q;
      phase_d  = phase_q;
      anim_d   = anim_q;
      case (state_q)
         IDLE, SHOW: begin
            if (req) begin
               if (bus.NB_Face >= face_t'(2)) begin
                  n_d      = bus.NB_Face;   // N is frozen for the whole roll
                  error_d  = 1'b0;
                  valid_d  = 1'b0;
                  phase_d  = '0;
                  anim_d   = '0;
                  result_d = face_t'(1);
                  state_d  = ROLL;
               end else begin
                  error_d  = 1'b1;          // too few faces: leave the display alone
               end
            end
         end
         ROLL: begin
            if (anim_q == AN_LAST) begin
               anim_d   = '0;
               result_d = (result_q == n_q) ? face_t'(1) : result_q + face_t'(1);
            end else begin
               anim_d   = anim_q + AN_W'(1);
            end
            if (phase_q == PH_LAST) begin
               r_d     = lfsr_state[FACE_W-1:0];
               state_d = REDUCE;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         REDUCE: begin
            if (r_q >= n_q) begin
               r_d      = r_q - n_q;
            end else begin
               result_d = r_q + face_t'(1);
               valid_d  = 1'b1;
               state_d  = SHOW;
            end
         end
         default: state_d = IDLE;
      endcase
      rolling_d = (state_d == ROLL) || (state_d == REDUCE);
   end

   assign bus.Result  = result_q;
   assign bus.Rolling = rolling_q;
   assign bus.Valid   = valid_q;
   assign bus.Error   = error_q;

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller with a free-running LFSR reference and a roll timing model.
module tb_dice_roller;
   import dice_pkg::*;

   localparam int RC = 16;
   localparam int AD = 4;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   dice_roller_if bus ();

   dice_roller #(.ROLL_CYCLES(RC), .ANIM_DIV(AD), .LFSR_SEED(16'hACE1)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_result = 0;
   int exp_valid  = 0;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, feedback into bits 15,13,12,10 on a right shift.
   function automatic logic [15:0] step(input logic [15:0] s);
      logic o;
      o = s[0];
      s = s >> 1;
      if (o) s = s ^ ((16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10));
      return s;
   endfunction

   logic [15:0] m_lfsr = 16'hACE1;
   always @(posedge Clk) m_lfsr <= Reset ? 16'hACE1 : step(m_lfsr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(negedge Clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_result"},  bus.Result, 0);
      check({tag, "_rolling"}, bus.Rolling, 0);
      check({tag, "_valid"},   bus.Valid, 0);
      check({tag, "_error"},   bus.Error, 0);
   endtask

   // Press Roll with face count n, release after `hold` cycles (0 = leave it held),
   // and check the whole roll against the model. Returns the result and cycles used.
   task automatic roll_check(input int n, input bit mid_change, input int hold,
                             output int res, output int k);
      int lat;
      int r;
      k = 0;
      r = 0;
      bus.NB_Face = 7'(n);
      bus.Roll    = 1'b1;
      do begin
         tick(); k++;
         if (k == hold) bus.Roll = 1'b0;
      end while (!bus.Rolling && k < 10);
      check("req_latency", k, 3);
      check("error_clear", bus.Error, 0);
      check("valid_clear", bus.Valid, 0);
      for (int i = 0; i < RC; i++) begin
         if (i > 0) begin
            tick(); k++;
            if (k == hold) bus.Roll = 1'b0;
         end
         check("rolling", bus.Rolling, 1);
         check("anim", bus.Result, (i / AD) % n + 1);
         if (i == RC - 1) r = int'(m_lfsr[6:0]);
         if (mid_change && i == 5) bus.NB_Face = 7'd100;
      end
      lat = 0;
      do begin
         tick(); k++; lat++;
         if (k == hold) bus.Roll = 1'b0;
      end while (!bus.Valid && lat < 80);
      check("reduce_latency", lat, r / n + 2);
      check("draw", bus.Result, r % n + 1);
      check("range", (bus.Result >= 1 && int'(bus.Result) <= n), 1);
      check("rolling_done", bus.Rolling, 0);
      res        = int'(bus.Result);
      exp_result = r % n + 1;
      exp_valid  = 1;
   endtask

   task automatic wait_rolling(input int n);
      int k;
      k = 0;
      bus.NB_Face = 7'(n);
      bus.Roll    = 1'b1;
      tick();
      bus.Roll = 1'b0;
      do begin tick(); k++; end while (!bus.Rolling && k < 10);
      check("start_rolling", bus.Rolling, 1);
   endtask

   typedef struct {
      int face;
      bit exp_err;
   } vec_t;

   vec_t tbl[9];
   int   hist[7];
   int   res, k;

   initial begin
      tbl[0] = '{0, 1'b1};   tbl[1] = '{4, 1'b0};   tbl[2] = '{1, 1'b1};
      tbl[3] = '{8, 1'b0};   tbl[4] = '{10, 1'b0};  tbl[5] = '{12, 1'b0};
      tbl[6] = '{20, 1'b0};  tbl[7] = '{30, 1'b0};  tbl[8] = '{2, 1'b0};
      for (int f = 0; f < 7; f++) hist[f] = 0;

      bus.NB_Face = '0;
      bus.Roll    = 1'b0;

      // 1. reset, then idle with the LFSR tracking the model
      tick(); tick();
      check_zero("reset");
      check("reset_lfsr", dut.lfsr_state, 16'hACE1);
      Reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_zero("idle");
         check("idle_lfsr", dut.lfsr_state, m_lfsr);
      end

      // 2. N=6, one-cycle pulse, NB_Face changed mid-roll
      roll_check(6, 1'b1, 1, res, k);
      repeat (5) begin
         tick();
         check("show_hold", bus.Result, exp_result);
         check("show_valid", bus.Valid, 1);
      end

      // 3. N=100 with the button held for 500 cycles
      roll_check(100, 1'b0, 0, res, k);
      for (int j = k; j < 500; j++) begin
         tick();
         check("held_valid", bus.Valid, 1);
         check("held_rolling", bus.Rolling, 0);
         check("held_result", bus.Result, exp_result);
      end
      bus.Roll = 1'b0;
      repeat (6) tick();
      check("release_no_roll", bus.Rolling, 0);
      check("release_result", bus.Result, exp_result);

      // 4. table of face counts: errors keep the display, valid ones roll
      Reset = 1'b1; tick(); Reset = 1'b0;
      exp_result = 0; exp_valid = 0;
      for (int t = 0; t < 9; t++) begin
         if (tbl[t].exp_err) begin
            bus.NB_Face = 7'(tbl[t].face);
            bus.Roll    = 1'b1;
            tick();
            bus.Roll = 1'b0;
            repeat (5) tick();
            check("err_flag", bus.Error, 1);
            check("err_rolling", bus.Rolling, 0);
            check("err_result", bus.Result, exp_result);
            check("err_valid", bus.Valid, exp_valid);
            check("err_state", dut.state_q, exp_valid ? SHOW : IDLE);
         end else begin
            roll_check(tbl[t].face, 1'b0, 1, res, k);
         end
      end

      // 5. reset in the 8th ROLL cycle, then in a REDUCE cycle
      wait_rolling(6);
      repeat (7) tick();
      Reset = 1'b1; tick();
      check_zero("rst_roll");
      check("rst_roll_state", dut.state_q, IDLE);
      check("rst_roll_lfsr", dut.lfsr_state, 16'hACE1);
      Reset = 1'b0;
      tick();
      wait_rolling(6);
      repeat (RC) tick();
      check("in_reduce", dut.state_q, REDUCE);
      Reset = 1'b1; tick();
      check_zero("rst_reduce");
      check("rst_reduce_state", dut.state_q, IDLE);
      check("rst_reduce_lfsr", dut.lfsr_state, 16'hACE1);
      Reset = 1'b0;

      // 6. 600 back-to-back N=6 rolls with random gaps
      for (int t = 0; t < 600; t++) begin
         repeat ($urandom_range(0, 3)) tick();
         roll_check(6, 1'b0, 1, res, k);
         if (res >= 1 && res <= 6) hist[res]++;
      end
      for (int f = 1; f <= 6; f++)
         check("face_count_ok", (hist[f] >= 60 && hist[f] <= 140), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
